// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO port: register map and arm-counter sizing.
package gpio_pkg;

    typedef enum logic [2:0] {
        GPIO_MODER = 3'd0,
        GPIO_ODR   = 3'd1,
        GPIO_IDR   = 3'd2,
        GPIO_SETR  = 3'd3,
        GPIO_CLRR  = 3'd4,
        GPIO_IER   = 3'd5,
        GPIO_EDGER = 3'd6,
        GPIO_ISR   = 3'd7
    } gpio_reg_e;

    // Bits needed to hold the arm count, which saturates at sync_stages+1.
    function automatic int unsigned arm_cnt_w(input int unsigned sync_stages);
        return $clog2(sync_stages + 2);
    endfunction

endpackage

// File: rtl/gpio_port_if.sv
// Word-addressed peripheral bus between the decoder/read mux and one GPIO port.
interface gpio_port_if;
    logic        sel;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wData;
    logic [31:0] rData;

    modport master (output sel, output we, output addr, output wData, input rData);
    modport slave  (input sel, input we, input addr, input wData, output rData);
endinterface

// File: rtl/gpio_sync.sv
// Multi-stage input synchroniser plus one extra flop holding the previous sample.
module gpio_sync #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] prev_o
);
    logic [STAGES-1:0][WIDTH-1:0] chain_q;
    logic [WIDTH-1:0]             prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= '0;
            prev_q  <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], in_i};
            prev_q  <= chain_q[STAGES-1];
        end
    end

    assign sync_o = chain_q[STAGES-1];
    assign prev_o = prev_q;
endmodule

// File: rtl/gpio_port.sv
// Bidirectional GPIO port: direction/output registers, atomic set/clear,
// synchronised readback and per-pin edge interrupts with W1C status.
module gpio_port
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    gpio_port_if.slave       bus,
    input  logic [WIDTH-1:0] ioIn,
    output logic [WIDTH-1:0] ioOut,
    output logic [WIDTH-1:0] ioOe,
    output logic             irq
);
    localparam int unsigned CW = arm_cnt_w(SYNC_STAGES);
    localparam logic [CW-1:0] ARM_MAX = CW'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] moder_q, moder_d;
    logic [WIDTH-1:0] odr_q, odr_d;
    logic [WIDTH-1:0] ier_q, ier_d;
    logic [WIDTH-1:0] edger_q, edger_d;
    logic [WIDTH-1:0] isr_q, isr_d;
    logic [CW-1:0]    arm_q, arm_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] sync_w, prev_w, evt_w, clr_w, wdat_w, rd_w;
    logic             armed_w, wr_w;
    gpio_reg_e        reg_sel;

    gpio_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .reset  (reset),
        .in_i   (ioIn),
        .sync_o (sync_w),
        .prev_o (prev_w)
    );

    assign reg_sel = gpio_reg_e'(bus.addr);
    assign wr_w    = bus.sel & bus.we;
    assign wdat_w  = bus.wData[WIDTH-1:0];
    assign armed_w = (arm_q == ARM_MAX);
    assign evt_w   = (edger_q & ~sync_w & prev_w) | (~edger_q & sync_w & ~prev_w);

    always_comb begin
        moder_d = moder_q;
        odr_d   = odr_q;
        ier_d   = ier_q;
        edger_d = edger_q;
        clr_w   = '0;
        if (wr_w) begin
            unique case (reg_sel)
                GPIO_MODER: moder_d = wdat_w;
                GPIO_ODR:   odr_d   = wdat_w;
                GPIO_SETR:  odr_d   = odr_q | wdat_w;
                GPIO_CLRR:  odr_d   = odr_q & ~wdat_w;
                GPIO_IER:   ier_d   = wdat_w;
                GPIO_EDGER: edger_d = wdat_w;
                GPIO_ISR:   clr_w   = wdat_w;
                default:    ;
            endcase
        end
        // Set is applied after clear so a coinciding event keeps the flag.
        isr_d = (isr_q & ~clr_w) | (evt_w & {WIDTH{armed_w}});
        arm_d = armed_w ? arm_q : arm_q + 1'b1;
        irq_d = |(isr_q & ier_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            moder_q <= '0;
            odr_q   <= '0;
            ier_q   <= '0;
            edger_q <= '0;
            isr_q   <= '0;
            arm_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            moder_q <= moder_d;
            odr_q   <= odr_d;
            ier_q   <= ier_d;
            edger_q <= edger_d;
            isr_q   <= isr_d;
            arm_q   <= arm_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        rd_w = '0;
        if (bus.sel) begin
            unique case (reg_sel)
                GPIO_MODER: rd_w = moder_q;
                GPIO_ODR:   rd_w = odr_q;
                GPIO_IDR:   rd_w = sync_w;
                GPIO_IER:   rd_w = ier_q;
                GPIO_EDGER: rd_w = edger_q;
                GPIO_ISR:   rd_w = isr_q;
                default:    rd_w = '0;
            endcase
        end
    end

    assign bus.rData = 32'(rd_w);
    assign ioOe      = moder_q;
    assign ioOut     = odr_q & moder_q;
    assign irq       = irq_q;
endmodule
